// File: rtl/uart_tx_fifo.sv
// Transmit FIFO plus feeder FSM that chains UART frames back-to-back.
// Define UART_TX_FIFO_OVF_EN to build the sticky write-overflow flag.
module uart_tx_fifo #(
    parameter int N          = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [N-1:0]          wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  ovf,
    input  logic                  ovf_clr,
    output logic                  tx_start,
    output logic [N-1:0]          tx_data,
    input  logic                  tx_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] LVL_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_RDY,
        S_CHAIN,
        S_DRAIN
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [N-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  pop;

    assign full   = (level == LVL_FULL);
    assign empty  = (level == LVL_ZERO);
    assign wr_acc = wr_en && !full;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            tx_data <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= mem[rd_ptr];
            end
            unique case ({wr_acc, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Start in CHAIN follows ready so it drops the cycle the transmitter takes it.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_start   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tx_start   = 1'b1;
                state_next = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (tx_ready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = S_CHAIN;
                    end else begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_CHAIN: begin
                if (tx_ready) begin
                    tx_start = 1'b1;
                end else begin
                    state_next = S_WAIT_RDY;
                end
            end
            S_DRAIN: begin
                if (!tx_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef UART_TX_FIFO_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo with a frame-level transmitter model.
// Honours UART_TX_FIFO_OVF_EN for the expected overflow flag.
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif
    localparam int BT = 4;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       ovf;
    logic       ovf_clr;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;

    logic use_model;
    logic force_rdy;

    int n_chk = 0;
    int n_err = 0;

    uart_tx_fifo #(.N(8), .DEPTH_LOG2(4)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .empty(empty),
        .level(level),
        .ovf(ovf),
        .ovf_clr(ovf_clr),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_ready(tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transmitter model: ready only during the stop bit, next frame queued
    // one edge after start is taken and launched as the stop bit ends.
    logic       m_busy = 1'b0;
    logic       m_acc = 1'b0;
    logic       m_nxt_v = 1'b0;
    logic [3:0] m_bit = '0;
    int         m_tick = 0;
    logic [9:0] m_frame = '1;
    logic [7:0] m_nxt = '0;
    int         m_chain = 0;
    logic       line;
    logic       mdl_ready;

    assign mdl_ready = m_busy && (m_bit == 4'd9) && !m_acc && !m_nxt_v;
    assign tx_ready  = use_model ? mdl_ready : force_rdy;
    assign line      = m_busy ? m_frame[m_bit] : 1'b1;

    always @(posedge clk) begin
        if (rst || !use_model) begin
            m_busy  <= 1'b0;
            m_acc   <= 1'b0;
            m_nxt_v <= 1'b0;
            m_bit   <= '0;
            m_tick  <= 0;
        end else begin
            if (tx_start && (!m_busy || m_bit == 4'd9) && !m_acc && !m_nxt_v)
                m_acc <= 1'b1;
            if (m_acc) begin
                m_acc   <= 1'b0;
                m_nxt_v <= 1'b1;
                m_nxt   <= tx_data;
            end
            if (m_busy) begin
                if (m_tick == BT - 1) begin
                    m_tick <= 0;
                    if (m_bit == 4'd9) begin
                        if (m_nxt_v) begin
                            m_frame <= {1'b1, m_nxt, 1'b0};
                            m_bit   <= '0;
                            m_nxt_v <= 1'b0;
                            m_chain <= m_chain + 1;
                        end else begin
                            m_busy <= 1'b0;
                        end
                    end else begin
                        m_bit <= m_bit + 4'd1;
                    end
                end else begin
                    m_tick <= m_tick + 1;
                end
            end else if (m_nxt_v) begin
                m_busy  <= 1'b1;
                m_bit   <= '0;
                m_tick  <= 0;
                m_frame <= {1'b1, m_nxt, 1'b0};
                m_nxt_v <= 1'b0;
            end
        end
    end

    // Line receiver: samples mid-bit, collects decoded bytes.
    logic [7:0] rx_q[$];
    logic       rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = '0;

    always @(negedge clk) begin
        if (rst) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (!line) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % BT == BT / 2) begin
                if (rx_cnt / BT >= 1 && rx_cnt / BT <= 8)
                    rx_sh[rx_cnt / BT - 1] = line;
                if (rx_cnt / BT == 9) begin
                    chk("rx_stop", line, 1);
                    rx_q.push_back(rx_sh);
                    rx_busy = 1'b0;
                end
            end
        end
    end

    // Scoreboard: FIFO contents as a queue; each rising tx_start marks the
    // pop made on the previous edge.
    logic [7:0] sb_q[$];
    logic [7:0] wr_log[$];
    logic       rec_rst = 1'b1;
    logic       rec_wr = 1'b0;
    logic [7:0] rec_data = '0;
    int         rec_lvl = 0;
    logic       rec_clr = 1'b0;
    logic       prev_start = 1'b0;
    logic       m_ovf = 1'b0;
    logic       rose;
    int         rise_rdy = 0;
    int         max_lvl = 0;

    always @(negedge clk) begin
        rose = tx_start && !prev_start;
        if (rec_rst) begin
            sb_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (rose) begin
                chk("pop_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    chk("pop_data", tx_data, sb_q[0]);
                    void'(sb_q.pop_front());
                end
                if (tx_ready) rise_rdy++;
            end
            if (rec_wr && rec_lvl < 16) begin
                sb_q.push_back(rec_data);
                wr_log.push_back(rec_data);
            end
            if (rec_wr && rec_lvl == 16) m_ovf = OVF_ON;
            else if (rec_clr) m_ovf = 1'b0;
        end
        chk("level", level, sb_q.size());
        chk("full", full, sb_q.size() == 16);
        chk("empty", empty, sb_q.size() == 0);
        chk("ovf", ovf, m_ovf);
        if (int'(level) > max_lvl) max_lvl = int'(level);
        rec_rst    = rst;
        rec_wr     = wr_en;
        rec_data   = wr_data;
        rec_lvl    = sb_q.size();
        rec_clr    = ovf_clr;
        prev_start = tx_start;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        wr_en = 1'b0;
        ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wr_log.delete();
        rx_q.delete();
    endtask

    task automatic wait_rx(input int n, input int budget);
        int t = 0;
        while (rx_q.size() < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("rx_count", rx_q.size(), n);
    endtask

    task automatic cmp_rx();
        chk("rx_len", rx_q.size(), wr_log.size());
        for (int i = 0; i < rx_q.size() && i < wr_log.size(); i++)
            chk("rx_byte", rx_q[i], wr_log[i]);
    endtask

    task automatic single_launch(input logic [7:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1;
        wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        chk("sl_lvl1", level, 1);
        chk("sl_start0", tx_start, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sl_start1", tx_start, 1);
        chk("sl_data", tx_data, d);
        chk("sl_lvl0", level, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sl_pulse", tx_start, 0);
    endtask

    logic [7:0] ow[17];
    int c0;
    int r0;
    int t;

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = '0;
        ovf_clr = 1'b0;
        use_model = 1'b1;
        force_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_ovf", ovf, 0);

        single_launch(8'hA5);
        wait_rx(1, 200);
        cmp_rx();
        repeat (10) @(posedge clk);

        wr_log.delete();
        rx_q.delete();
        c0 = m_chain;
        r0 = rise_rdy;
        foreach (ow[i]) ow[i] = 8'h11 * 8'(i + 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            wr_en = 1'b1;
            wr_data = ow[i];
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_rx(3, 400);
        chk("burst_chain", m_chain - c0, 2);
        chk("burst_rise_rdy", rise_rdy - r0, 2);
        repeat (10) @(posedge clk);
        single_launch(8'h5A);
        wait_rx(4, 200);
        cmp_rx();
        repeat (10) @(posedge clk);

        wr_log.delete();
        rx_q.delete();
        max_lvl = 0;
        t = 0;
        while (wr_log.size() < 40 && t < 4000) begin
            @(posedge clk); #1;
            wr_en = ($urandom_range(0, 3) == 0);
            wr_data = 8'($urandom);
            t++;
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        chk("wrap_budget", t < 4000, 1);
        @(negedge clk);
        wait_rx(wr_log.size(), 3000);
        cmp_rx();
        chk("wrap_lvl_max", max_lvl, 16);

        use_model = 1'b0;
        force_rdy = 1'b0;
        do_reset();
        @(posedge clk); #1;
        wr_en = 1'b1;
        wr_data = 8'h3C;
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        foreach (ow[i]) ow[i] = 8'($urandom);
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = ow[i];
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        @(negedge clk);
        chk("ovr_full", full, 1);
        chk("ovr_level", level, 16);
        chk("ovr_flag", ovf, OVF_ON);
        @(posedge clk); #1;
        wr_en = 1'b1;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        chk("ovf_set_wins", ovf, OVF_ON);
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", ovf, 0);

        @(posedge clk); #1;
        wr_en = 1'b1;
        wr_data = 8'hEE;
        force_rdy = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("wp_level", level, 15);
        chk("wp_start", tx_start, 1);
        chk("wp_data", tx_data, ow[0]);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_start", tx_start, 0);
        chk("rst_mid_level", level, 0);
        rst = 1'b0;
        force_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
